// File: rtl/step_pulse_gen_if.sv
// Control/status bundle for step_pulse_gen. The endstop_i lines exist only when
// STEP_PULSE_GEN_ENDSTOP_EN is defined.
interface step_pulse_gen_if;
  logic             step_tick_i;
  logic [7:0][63:0] speed_i;
  logic [7:0]       enable_i;
  logic [7:0]       clear_mask_i;
  logic [2:0]       pos_sel_i;
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
  logic [7:0]       endstop_i;
`endif
  logic [31:0]      pos_out_o;
  logic [7:0]       step_o;
  logic [7:0]       dir_o;
  logic             busy_o;
  logic [7:0]       overrun_o;
  logic             tick_lost_o;

  modport master (
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    output endstop_i,
`endif
    output step_tick_i, speed_i, enable_i, clear_mask_i, pos_sel_i,
    input  pos_out_o, step_o, dir_o, busy_o, overrun_o, tick_lost_o
  );

  modport slave (
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    input  endstop_i,
`endif
    input  step_tick_i, speed_i, enable_i, clear_mask_i, pos_sel_i,
    output pos_out_o, step_o, dir_o, busy_o, overrun_o, tick_lost_o
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Eight-channel speed integrator with STEP/DIR pulse generation, one shared adder
// time-multiplexed over the channels. Optional endstop gating: STEP_PULSE_GEN_ENDSTOP_EN.
module step_pulse_gen #(
  parameter int STEP_BIT  = 32,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 20
) (
  input  logic            clk,
  input  logic            rst,
  step_pulse_gen_if.slave io
);
  localparam int            CW         = 16;
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2
  } pulse_st_e;

  logic          busy_q, busy_d;
  logic [2:0]    slot_q, slot_d;
  logic          tick_lost_q, tick_lost_d;
  logic [63:0]   acc_q [8];
  logic [63:0]   acc_d [8];
  logic [31:0]   pos_q [8];
  logic [31:0]   pos_d [8];
  pulse_st_e     st_q [8];
  pulse_st_e     st_d [8];
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [7:0]    dir_q, dir_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    ovr_q, ovr_d;
  logic [31:0]   pos_out_q, pos_out_d;

  logic [63:0]   spd_s, acc_cur_s, sum_s;
  logic          slot_en_s, req_s, big_s, blk_s;

  // Shared adder and step-request decode for the channel owning the current slot
  always_comb begin
    spd_s     = io.speed_i[slot_q];
    acc_cur_s = acc_q[slot_q];
    sum_s     = acc_cur_s + spd_s;
    slot_en_s = busy_q & io.enable_i[slot_q];
    req_s     = slot_en_s & (sum_s[63:STEP_BIT] != acc_cur_s[63:STEP_BIT]);
    // Negative speed reaches a full step when it is -2^STEP_BIT or below
    if (spd_s[63]) begin
      big_s = ~(&spd_s[63:STEP_BIT]) | ~(|spd_s[STEP_BIT-1:0]);
    end else begin
      big_s = |spd_s[63:STEP_BIT];
    end
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    blk_s = req_s & spd_s[63] & io.endstop_i[slot_q];
`else
    blk_s = 1'b0;
`endif
  end

  // Scan sequencing: one slot per clk while busy, late ticks flagged
  always_comb begin
    busy_d      = busy_q;
    slot_d      = slot_q;
    tick_lost_d = tick_lost_q;
    if (busy_q) begin
      tick_lost_d = tick_lost_q | io.step_tick_i;
      if (slot_q == 3'd7) begin
        busy_d = 1'b0;
        slot_d = 3'd0;
      end else begin
        busy_d = 1'b1;
        slot_d = slot_q + 3'd1;
      end
    end else if (io.step_tick_i) begin
      busy_d = 1'b1;
      slot_d = 3'd0;
    end else begin
      busy_d = 1'b0;
      slot_d = slot_q;
    end
  end

  // Per-channel pulse FSM, accumulator write-back and position counting
  always_comb begin
    logic hit, req_ch, enter;
    hit    = 1'b0;
    req_ch = 1'b0;
    enter  = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      st_d[ch]  = st_q[ch];
      cnt_d[ch] = cnt_q[ch];
      dir_d[ch] = dir_q[ch];
      hit       = slot_en_s & (slot_q == 3'(ch));
      req_ch    = hit & req_s & ~blk_s;
      enter     = 1'b0;
      case (st_q[ch])
        ST_IDLE: begin
          if (req_ch && (spd_s[63] != dir_q[ch])) begin
            dir_d[ch] = spd_s[63];
            st_d[ch]  = ST_SETUP;
            cnt_d[ch] = SETUP_LAST;
          end else if (req_ch) begin
            st_d[ch]  = ST_PULSE;
            cnt_d[ch] = PULSE_LAST;
            enter     = 1'b1;
          end else begin
            st_d[ch]  = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_q[ch] == CNT_ZERO) begin
            st_d[ch]  = ST_PULSE;
            cnt_d[ch] = PULSE_LAST;
            enter     = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q[ch] == CNT_ZERO) begin
            st_d[ch] = ST_IDLE;
          end else begin
            cnt_d[ch] = cnt_q[ch] - CNT_ONE;
          end
        end
        default: begin
          st_d[ch]  = ST_IDLE;
          cnt_d[ch] = CNT_ZERO;
        end
      endcase
      ovr_d[ch]  = ovr_q[ch] | (hit & big_s & ~blk_s) | (req_ch & (st_q[ch] != ST_IDLE));
      step_d[ch] = (st_d[ch] == ST_PULSE);
      // Clear has priority over both the scan write and the step count
      if (io.clear_mask_i[ch]) begin
        acc_d[ch] = 64'd0;
        pos_d[ch] = 32'd0;
      end else begin
        acc_d[ch] = hit ? sum_s : acc_q[ch];
        if (enter) begin
          pos_d[ch] = dir_q[ch] ? (pos_q[ch] - 32'd1) : (pos_q[ch] + 32'd1);
        end else begin
          pos_d[ch] = pos_q[ch];
        end
      end
    end
    pos_out_d = pos_q[io.pos_sel_i];
  end

  // State registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      slot_q      <= 3'd0;
      tick_lost_q <= 1'b0;
      dir_q       <= 8'd0;
      step_q      <= 8'd0;
      ovr_q       <= 8'd0;
      pos_out_q   <= 32'd0;
      for (int ch = 0; ch < 8; ch++) begin
        acc_q[ch] <= 64'd0;
        pos_q[ch] <= 32'd0;
        st_q[ch]  <= ST_IDLE;
        cnt_q[ch] <= CNT_ZERO;
      end
    end else begin
      busy_q      <= busy_d;
      slot_q      <= slot_d;
      tick_lost_q <= tick_lost_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      ovr_q       <= ovr_d;
      pos_out_q   <= pos_out_d;
      for (int ch = 0; ch < 8; ch++) begin
        acc_q[ch] <= acc_d[ch];
        pos_q[ch] <= pos_d[ch];
        st_q[ch]  <= st_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign io.pos_out_o   = pos_out_q;
  assign io.step_o      = step_q;
  assign io.dir_o       = dir_q;
  assign io.busy_o      = busy_q;
  assign io.overrun_o   = ovr_q;
  assign io.tick_lost_o = tick_lost_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized and directed bench for step_pulse_gen against a timeline-based reference
// model (pulse windows as cycle intervals, accumulators as plain signed integers).
module tb_step_pulse_gen;
  localparam int SB = 32;
  localparam int PW = 50;
  localparam int DS = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  step_pulse_gen_if bus ();

  step_pulse_gen #(.STEP_BIT(SB), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  logic signed [63:0] m_acc [8];
  logic [31:0]        m_pos [8];
  longint             m_start [8];
  longint             m_end [8];
  bit                 m_inc [8];
  logic [7:0]         m_dir, m_ovr;
  logic               m_tl;
  logic [31:0]        m_pos_out;
  longint             scan_t = -100;
  longint             cyc = 0;
  int                 errors = 0;
  int                 checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: advance from cycle cyc to cyc+1 using the inputs currently driven
  task automatic model_advance();
    longint c;
    bit busy_now, req, big, blk, neg;
    int ch;
    logic signed [63:0] spd, a, nw;
    c = cyc;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_acc[k] = 64'sd0; m_pos[k] = 32'd0; m_start[k] = 0; m_end[k] = 0; m_inc[k] = 1'b0;
      end
      m_dir = 8'd0; m_ovr = 8'd0; m_tl = 1'b0; m_pos_out = 32'd0; scan_t = -100;
    end else begin
      busy_now  = (c >= scan_t + 1) && (c <= scan_t + 8);
      m_pos_out = m_pos[bus.pos_sel_i];
      if (busy_now) begin
        ch = int'(c - scan_t - 1);
        if (bus.enable_i[ch]) begin
          spd = bus.speed_i[ch];
          a   = m_acc[ch];
          nw  = a + spd;
          neg = (spd < 0);
          req = (nw >>> SB) != (a >>> SB);
          big = neg ? (spd <= -(64'sd1 <<< SB)) : (spd >= (64'sd1 <<< SB));
          blk = 1'b0;
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
          blk = req && neg && bus.endstop_i[ch];
`endif
          m_acc[ch] = nw;
          if (big && !blk) m_ovr[ch] = 1'b1;
          if (req && !blk) begin
            if (c >= m_end[ch]) begin
              if (neg != m_dir[ch]) begin
                m_dir[ch]   = neg;
                m_start[ch] = c + 1 + DS;
              end else begin
                m_start[ch] = c + 1;
              end
              m_end[ch] = m_start[ch] + PW;
              m_inc[ch] = 1'b1;
            end else begin
              m_ovr[ch] = 1'b1;
            end
          end
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (m_inc[k] && m_start[k] == c + 1) begin
          m_pos[k] = m_dir[k] ? (m_pos[k] - 32'd1) : (m_pos[k] + 32'd1);
          m_inc[k] = 1'b0;
        end
        if (bus.clear_mask_i[k]) begin
          m_acc[k] = 64'sd0;
          m_pos[k] = 32'd0;
        end
      end
      if (bus.step_tick_i) begin
        if (busy_now) m_tl = 1'b1;
        else scan_t = c;
      end
    end
    cyc = c + 1;
  endtask

  task automatic check_outputs();
    logic [7:0] es;
    for (int k = 0; k < 8; k++) es[k] = (cyc >= m_start[k]) && (cyc < m_end[k]);
    check_val("step", 64'(bus.step_o), 64'(es));
    check_val("dir", 64'(bus.dir_o), 64'(m_dir));
    check_val("busy", 64'(bus.busy_o), 64'((cyc >= scan_t + 1) && (cyc <= scan_t + 8)));
    check_val("overrun", 64'(bus.overrun_o), 64'(m_ovr));
    check_val("tick_lost", 64'(bus.tick_lost_o), 64'(m_tl));
    check_val("pos_out", 64'(bus.pos_out_o), 64'(m_pos_out));
  endtask

  task automatic step_clk();
    model_advance();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic tick();
    bus.step_tick_i = 1'b1;
    step_clk();
    bus.step_tick_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
  endtask

  task automatic zero_speeds();
    for (int k = 0; k < 8; k++) bus.speed_i[k] = 64'd0;
  endtask

  initial begin
    logic [31:0] r;
    bus.step_tick_i  = 1'b0;
    bus.enable_i     = 8'hFF;
    bus.clear_mask_i = 8'h00;
    bus.pos_sel_i    = 3'd0;
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    bus.endstop_i    = 8'h00;
`endif
    zero_speeds();
    do_reset();
    check_val("reset_pos_out", 64'(bus.pos_out_o), 64'd0);

    // Half-step speed: a step every second tick
    bus.speed_i[0] = 64'h0000_0000_8000_0000;
    for (int t = 0; t < 4; t++) begin
      tick();
      run(199);
    end
    check_val("half_speed_pos", 64'(bus.pos_out_o), 64'd2);

    // Negative full-step speed: direction change with setup
    do_reset(); zero_speeds();
    bus.pos_sel_i  = 3'd3;
    bus.speed_i[3] = 64'hFFFF_FFFF_0000_0000;
    tick();
    run(100);
    check_val("neg_pos", 64'(bus.pos_out_o), 64'h0000_0000_FFFF_FFFF);
    check_val("neg_dir", 64'(bus.dir_o[3]), 64'd1);

    // Overspeed and a tick arriving mid-scan
    do_reset(); zero_speeds();
    bus.pos_sel_i  = 3'd1;
    bus.speed_i[1] = 64'h0000_0002_0000_0000;
    tick();
    run(3);
    tick();
    run(60);
    check_val("tick_lost", 64'(bus.tick_lost_o), 64'd1);
    check_val("overspeed_ovr", 64'(bus.overrun_o[1]), 64'd1);
    check_val("overspeed_pos", 64'(bus.pos_out_o), 64'd1);

    // Ticks faster than the pulse: every second request dropped
    do_reset(); zero_speeds();
    bus.pos_sel_i  = 3'd2;
    bus.speed_i[2] = 64'h0000_0001_0000_0000;
    for (int t = 0; t < 10; t++) begin
      tick();
      run(29);
    end
    run(80);
    check_val("fast_pos", 64'(bus.pos_out_o), 64'd5);
    check_val("fast_ovr", 64'(bus.overrun_o[2]), 64'd1);

    // Clear in channel 0's own slot beats the write and the count
    do_reset(); zero_speeds();
    bus.pos_sel_i  = 3'd0;
    bus.speed_i[0] = 64'h0000_0001_0000_0000;
    tick();
    bus.clear_mask_i = 8'h01;
    step_clk();
    bus.clear_mask_i = 8'h00;
    run(60);
    check_val("clear_pos", 64'(bus.pos_out_o), 64'd0);
    tick();
    run(10);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    check_val("rst_mid_pulse", 64'(bus.step_o), 64'd0);

`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    do_reset(); zero_speeds();
    bus.pos_sel_i  = 3'd5;
    bus.endstop_i  = 8'h20;
    bus.speed_i[5] = 64'hFFFF_FFFF_0000_0000;
    for (int t = 0; t < 2; t++) begin tick(); run(150); end
    check_val("endstop_blocked", 64'(bus.pos_out_o), 64'd0);
    bus.speed_i[5] = 64'h0000_0001_0000_0000;
    for (int t = 0; t < 2; t++) begin tick(); run(150); end
    check_val("endstop_fwd", 64'(bus.pos_out_o), 64'd2);
    bus.endstop_i  = 8'h00;
`endif

    // Random phase
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0: bus.speed_i[k] = 64'd0;
          1: bus.speed_i[k] = {{32{r[31]}}, r};
          2: bus.speed_i[k] = (r[0] ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0001_0000_0000) + 64'({r[7:0]});
          default: bus.speed_i[k] = {$urandom, r};
        endcase
      end
      bus.enable_i = 8'($urandom) | 8'($urandom);
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
      bus.endstop_i = 8'($urandom) & 8'($urandom);
`endif
      tick();
      for (int g = $urandom_range(1, 90); g > 0; g--) begin
        bus.pos_sel_i    = 3'($urandom);
        bus.clear_mask_i = ($urandom_range(0, 49) == 0) ? 8'($urandom) : 8'h00;
        step_clk();
      end
      bus.clear_mask_i = 8'h00;
    end
    run(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
